// File: rtl/close_ab_arbiter_if.sv
// Bundle of requester-side and unit-side signals around the close_ab arbiter.
// master is the arbiter's view; slave is the view of the requesters plus the unit.
interface close_ab_arbiter_if #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 8
);
    logic [1:0]       Req;
    logic [WIDTH-1:0] Ain0;
    logic [WIDTH-1:0] Bin0;
    logic [WIDTH-1:0] Ain1;
    logic [WIDTH-1:0] Bin1;
    logic [1:0]       ReqAck;
    logic [1:0]       Gnt;
    logic [1:0]       Done;
    logic [WIDTH-1:0] Result;
    logic             ResFlag;
    logic [CNT_W-1:0] Cycles;
    logic [WIDTH-1:0] U_Ain;
    logic [WIDTH-1:0] U_Bin;
    logic             U_Start;
    logic             U_Ack;
    logic [WIDTH-1:0] U_A;
    logic             U_Flag;
    logic             U_Qi;
    logic             U_Qd;

    modport master (
        input  Req, Ain0, Bin0, Ain1, Bin1, ReqAck,
        input  U_A, U_Flag, U_Qi, U_Qd,
        output Gnt, Done, Result, ResFlag, Cycles,
        output U_Ain, U_Bin, U_Start, U_Ack
    );

    modport slave (
        output Req, Ain0, Bin0, Ain1, Bin1, ReqAck,
        output U_A, U_Flag, U_Qi, U_Qd,
        input  Gnt, Done, Result, ResFlag, Cycles,
        input  U_Ain, U_Bin, U_Start, U_Ack
    );
endinterface

// File: rtl/close_ab_arbiter.sv
// Round-robin arbiter/sequencer sharing one make_A_close_to_B unit between two requesters.
// Runs Start/Ack with the unit and Done/ReqAck with the granted requester.
module close_ab_arbiter #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 8
) (
    input logic                 Clk,
    input logic                 Reset,
    close_ab_arbiter_if.master  bus
);

    typedef enum logic [2:0] {StIdle, StLaunch, StWait, StDone, StAcku} state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             start_q, start_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] ain_q, ain_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             win;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        win     = (bus.Req == 2'b11) ? ptr_q : bus.Req[1];
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        start_d  = 1'b0;
        ack_d    = 1'b0;
        ain_d    = ain_q;
        bin_d    = bin_q;
        result_d = result_q;
        flag_d   = flag_q;
        cycles_d = cycles_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.U_Qi && (bus.Req != 2'b00)) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    ain_d   = win ? bus.Ain1 : bus.Ain0;
                    bin_d   = win ? bus.Bin1 : bus.Bin0;
                    start_d = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (bus.U_Qd) begin
                    result_d = bus.U_A;
                    flag_d   = bus.U_Flag;
                    cycles_d = cnt_inc;
                    done_d   = gnt_q;
                    state_d  = StDone;
                end
            end
            StDone: begin
                // Only the granted requester's acknowledge releases the job.
                if ((bus.ReqAck & gnt_q) != 2'b00) begin
                    ptr_d   = ~gnt_q[1];
                    done_d  = 2'b00;
                    ack_d   = 1'b1;
                    state_d = StAcku;
                end
            end
            StAcku: begin
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            ptr_q    <= 1'b0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
            ain_q    <= '0;
            bin_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            cycles_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            start_q  <= start_d;
            ack_q    <= ack_d;
            ain_q    <= ain_d;
            bin_q    <= bin_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            cycles_q <= cycles_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.Gnt     = gnt_q;
    assign bus.Done    = done_q;
    assign bus.Result  = result_q;
    assign bus.ResFlag = flag_q;
    assign bus.Cycles  = cycles_q;
    assign bus.U_Ain   = ain_q;
    assign bus.U_Bin   = bin_q;
    assign bus.U_Start = start_q;
    assign bus.U_Ack   = ack_q;

endmodule

// File: doc/close_ab_arbiter.md
# close_ab_arbiter

Two-requester round-robin arbiter and sequencer for one shared make_A_close_to_B datapath unit. It accepts (Ain, Bin) jobs from two higher-order requesters and grants the unit to one of them. It drives the unit's Start/Ack handshake, captures the unit's result (A, Flag) and a per-job clock count, and returns them to the granted requester through a Done/Ack handshake. It sits between the requesters and the unit; the unit shares this block's Clk and Reset.

## Interface

- WIDTH, 12, data width of Ain/Bin/A
- CNT_W, 8, width of the per-job clock counter (saturating)

- Clk  in  1  system clock, all state updates on posedge
- Reset  in  1  synchronous, active-high; one clock, reset synchronous and active-high
- Req  in  2  per-requester job request, level; Req[i] belongs to requester i
- Ain0, Bin0  in  WIDTH each  requester 0 operands
- Ain1, Bin1  in  WIDTH each  requester 1 operands
- ReqAck  in  2  per-requester acknowledge of Done
- Gnt  out  2  one-hot grant, held from grant until job release
- Done  out  2  one-hot result-valid to the granted requester
- Result  out  WIDTH  captured unit A
- ResFlag  out  1  captured unit Flag
- Cycles  out  CNT_W  clocks spent in WAIT for the job
- U_Ain, U_Bin  out  WIDTH  operands to unit, stable for the whole job
- U_Start, U_Ack  out  1  unit handshake strobes
- U_A  in  WIDTH, U_Flag  in  1, U_Qi  in  1, U_Qd  in  1  unit result and state outputs

## Operation

- States: IDLE, LAUNCH, WAIT, DONE, ACKU. One-hot or binary encoding is acceptable.
- IDLE: a grant is issued only when U_Qi=1 and Req≠0.
  - Winner: if only one Req bit is high, that requester wins. If both are high, the priority pointer Ptr (1 bit) wins.
  - On the grant edge: latch the winner's Ain/Bin into U_Ain/U_Bin, set Gnt[winner], and go to LAUNCH.
- LAUNCH: U_Start=1 for exactly this one cycle. Clear the job counter. Go to WAIT.
- WAIT: increment the counter each cycle; it saturates at 2^CNT_W−1.
  - When U_Qd=1 is sampled: latch Result←U_A, ResFlag←U_Flag, and Cycles←counter value including this cycle.
  - Then go to DONE.
- DONE: Done[granted]=1.
  - If ReqAck[granted]=1 is sampled: set Ptr←other requester and go to ACKU.
  - ReqAck of the non-granted requester is ignored.
- ACKU: U_Ack=1 for exactly one cycle. Clear Gnt and go to IDLE.
- Result, ResFlag and Cycles hold their values until the next job's WAIT capture.
- Req is sampled only in IDLE. A requester that drops Req after its grant still receives Done.
- A requester that keeps Req high after its ReqAck is re-queued, and it loses any tie because Ptr has moved.
- Ain/Bin are sampled only on the grant edge. Later changes do not affect the running job.
- Ptr resets to 0, so requester 0 wins the first tie.

## Timing

- Reset values (registered outputs):
  - state=IDLE, Ptr=0, Gnt=00, Done=00, U_Start=0, U_Ack=0.
  - U_Ain=U_Bin=0, Result=0, ResFlag=0, Cycles=0.
- Reset asserted mid-job: every register returns to its reset value on the next edge, and the job is abandoned with no Done. The unit is reset by the same Reset, so no U_Ack is issued.
- Grant latency: Req high at IDLE edge k (with U_Qi=1) gives Gnt at k+1. U_Start is high during cycle k+1→k+2.
- Capture latency: U_Qd sampled at edge m gives Done high after m+1.
- Release latency: ReqAck sampled at edge n gives U_Ack high for cycle n+1→n+2, then IDLE. The earliest next grant is edge n+3, because U_Qi must be back to 1.
- Minimum job turnaround, with Qd one cycle after Start: 5 clocks from grant to next IDLE.
- Gnt and Done are never high for two requesters at once. Done is never high outside DONE.

## Test plan

Every scenario uses a bench stub unit: Qi in its INI state, Qd asserted L cycles after the Start edge, A=Bin−1, Flag=(Ain>Bin), and back to INI one edge after Ack.

- Reset, then Req=01, Ain0=138, Bin0=312, L=4 -> Gnt=01 one edge later, a single-cycle U_Start, then Done[0] with Result=311, ResFlag=0, Cycles=4. After ReqAck[0], a single U_Ack pulse and return to IDLE.
- Req=11 from reset, Ain1=400, Bin1=312 -> requester 0 served first. Then Gnt=10 with Result=311, ResFlag=1. Then requester 0 again if its Req is still high (alternation).
- During WAIT, change Ain0/Bin0 to 0/0 -> U_Ain/U_Bin remain 138/312 and Result=311.
- Assert ReqAck[1] while requester 0 is in DONE -> no transition and Done stays 01. Then ReqAck[0] -> released.
- L=300 with CNT_W=8 -> Cycles=255 (saturated) and Result correct.
- Assert Reset for one cycle mid-WAIT -> all outputs at their reset values next cycle, no Done, and a fresh Req=10 is then granted normally.
